// File: rtl/sr_latch_bank.sv
// rtl/sr_latch_bank.sv - clocked bank of N set/reset storage channels with saturating conflict counter
// Optional build macro: SR_SYNC_EN adds a 2-flop synchroniser on every set/reset bit.
module sr_latch_bank #(
  parameter int           N     = 4,
  parameter int           MODE  = 0,
  parameter logic [N-1:0] INIT  = {N{1'b0}},
  parameter int           CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     set,
  input  logic [N-1:0]     reset,
  input  logic             clr_cnt,
  output logic [N-1:0]     q,
  output logic [N-1:0]     qbar,
  output logic [N-1:0]     chg,
  output logic [CNT_W-1:0] conflict_cnt
);

  if (N < 1 || N > 32 || CNT_W < 2 || CNT_W > 16 || MODE < 0 || MODE > 3) begin : g_bad_param
    $fatal(1, "sr_latch_bank: illegal parameter set");
  end

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [N-1:0]     s_eff, r_eff;
  logic [N-1:0]     q_q, q_d, chg_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

`ifdef SR_SYNC_EN
  logic [N-1:0] s_meta_q, s_sync_q, r_meta_q, r_sync_q;

  // Cleared on reset so no pre-reset request can leak into the first update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_meta_q <= '0;
      s_sync_q <= '0;
      r_meta_q <= '0;
      r_sync_q <= '0;
    end else begin
      s_meta_q <= set;
      s_sync_q <= s_meta_q;
      r_meta_q <= reset;
      r_sync_q <= r_meta_q;
    end
  end

  assign s_eff = s_sync_q;
  assign r_eff = r_sync_q;
`else
  assign s_eff = set;
  assign r_eff = reset;
`endif

  always_comb begin
    q_d = q_q;
    for (int i = 0; i < N; i++) begin
      case ({s_eff[i], r_eff[i]})
        2'b10: q_d[i] = 1'b1;
        2'b01: q_d[i] = 1'b0;
        2'b11: begin
          case (MODE)
            0:       q_d[i] = 1'b0;
            1:       q_d[i] = 1'b1;
            3:       q_d[i] = ~q_q[i];
            default: q_d[i] = q_q[i];
          endcase
        end
        default: q_d[i] = q_q[i];
      endcase
    end
  end

  // Clear wins over a same-edge conflict
  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt) begin
      cnt_d = '0;
    end else if ((|(s_eff & r_eff)) && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q   <= INIT;
      chg_q <= '0;
      cnt_q <= '0;
    end else begin
      q_q   <= q_d;
      chg_q <= q_d ^ q_q;
      cnt_q <= cnt_d;
    end
  end

  assign q            = q_q;
  assign qbar         = ~q_q;
  assign chg          = chg_q;
  assign conflict_cnt = cnt_q;

endmodule
